// File: rtl/irst_pkg.sv
// Shared types and defaults for the IRST register-state signature compactor.
package irst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } irst_state_t;

    localparam int          IRST_NUM_REGS = 8;
    localparam logic [31:0] IRST_SEED     = 32'hFFFF_FFFF;
    localparam logic [31:0] IRST_POLY     = 32'h0040_0007;

endpackage

// File: rtl/irst_sig_compactor_misr32_step.sv
// One step of the 32-bit MISR: shift, conditional polynomial feedback,
// and fold of the 16-bit data word duplicated into both halves.
module misr32_step (
    input  logic [31:0] misr,
    input  logic [15:0] data,
    input  logic [31:0] poly,
    output logic [31:0] misr_next
);

    assign misr_next = {misr[30:0], 1'b0}
                     ^ (misr[31] ? poly : 32'h0000_0000)
                     ^ {data, data};

endmodule

// File: rtl/irst_sig_compactor.sv
// Walks the register file one address per cycle after self-test and folds
// every value into a 32-bit MISR, exposing a sticky done flag.
module irst_sig_compactor
    import irst_pkg::*;
#(
    parameter int          NUM_REGS = IRST_NUM_REGS,
    parameter int          ADDR_W   = 3,
    parameter logic [31:0] SEED     = IRST_SEED,
    parameter logic [31:0] POLY     = IRST_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] scan_addr,
    input  logic [15:0]       scan_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       signature
);

    // One extra index bit lets NUM_REGS == 2**ADDR_W finish without wrapping.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);

    irst_state_t       state;
    irst_state_t       next_state;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       misr;
    logic [31:0]       misr_next;
    logic              start_scan;
    logic              last_capture;

    assign start_scan   = start && (state != SCAN);
    assign last_capture = (state == SCAN) && (idx == LAST_IDX);

    misr32_step u_step (
        .misr      (misr),
        .data      (scan_data),
        .poly      (POLY),
        .misr_next (misr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (idx == LAST_IDX) next_state = DONE;
            DONE:    if (start) next_state = SCAN;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            SCAN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The address stops advancing on the last capture so DONE shows NUM_REGS-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misr   <= SEED;
            idx    <= '0;
            addr_q <= '0;
        end else if (start_scan) begin
            misr   <= SEED;
            idx    <= '0;
            addr_q <= '0;
        end else if (state == SCAN) begin
            misr <= misr_next;
            idx  <= idx + (ADDR_W + 1)'(1);
            if (!last_capture) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    assign scan_addr = addr_q;
    assign signature = misr;

endmodule
